// File: rtl/idex_pkg.sv
// rtl/idex_pkg.sv - shared types and constants for the ID/EX skid register
//
// Contents:
//   idex_state_t    occupancy state: ST_EMPTY, ST_ONE (main valid), ST_TWO (main + skid valid)
//   IDEX_*          default payload geometry and the default NOP opcode
//   idex_payload_t  payload struct at the default geometry (opcode, ops, imm)
//   idex_entries()  number of valid entries held in a given state
package idex_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } idex_state_t;

   localparam int IDEX_DATA_W  = 32;
   localparam int IDEX_OP_W    = 5;
   localparam int IDEX_NUM_OPS = 3;
   localparam int IDEX_IMM_W   = 32;

   localparam logic [IDEX_OP_W-1:0] IDEX_NOP_OPCODE = '0;

   typedef struct packed {
      logic [IDEX_OP_W-1:0]                opcode;
      logic [IDEX_NUM_OPS*IDEX_DATA_W-1:0] ops;
      logic [IDEX_IMM_W-1:0]               imm;
   } idex_payload_t;

   function automatic logic [1:0] idex_entries(idex_state_t s);
      case (s)
         ST_ONE:  return 2'd1;
         ST_TWO:  return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/idex_perf_counters.sv
// rtl/idex_perf_counters.sv - saturating stall and flush-drop counters
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_stall             output held valid but not accepted this cycle
//   i_flush             flush asserted this cycle
//   i_drop_cnt          valid entries discarded if this cycle flushes (0..2)
//   o_stall_cnt         stall cycles seen, saturating at all-ones
//   o_flush_drop_cnt    entries discarded by flushes, saturating at all-ones
module idex_perf_counters (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_stall,
   input  logic        i_flush,
   input  logic [1:0]  i_drop_cnt,
   output logic [31:0] o_stall_cnt,
   output logic [31:0] o_flush_drop_cnt
);

   logic [31:0] r_stall_cnt;
   logic [31:0] r_drop_cnt;
   logic [32:0] w_drop_sum;

   // One extra bit catches the carry so the add saturates instead of wrapping.
   assign w_drop_sum = {1'b0, r_drop_cnt} + {31'b0, i_drop_cnt};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
         r_drop_cnt  <= '0;
      end else begin
         if (i_stall && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 32'd1;
         if (i_flush)
            r_drop_cnt <= w_drop_sum[32] ? '1 : w_drop_sum[31:0];
      end
   end

   assign o_stall_cnt      = r_stall_cnt;
   assign o_flush_drop_cnt = r_drop_cnt;

endmodule

// File: rtl/id_ex_skid_reg.sv
// rtl/id_ex_skid_reg.sv - ID/EX pipeline register with valid/ready and 2-entry skid
//
// Optional feature: IDEX_PERF_CNT_EN adds stall_cnt and flush_drop_cnt outputs.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   flush                           synchronous kill of all held entries
//   in_valid/in_ready               decode-side handshake (in_ready is registered)
//   in_opcode/in_ops/in_imm         decode payload (ops lane 0 = Rd, 1 = Rs, 2 = Rt)
//   out_valid/out_ready             execute-side handshake
//   out_opcode/out_ops/out_imm      execute payload, NOP/zero when out_valid=0
//   stall_cnt, flush_drop_cnt       performance counters (IDEX_PERF_CNT_EN only)
module id_ex_skid_reg
   import idex_pkg::*;
#(
   parameter int              DATA_W     = IDEX_DATA_W,
   parameter int              OP_W       = IDEX_OP_W,
   parameter int              NUM_OPS    = IDEX_NUM_OPS,
   parameter int              IMM_W      = IDEX_IMM_W,
   parameter logic [OP_W-1:0] NOP_OPCODE = OP_W'(IDEX_NOP_OPCODE)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [OP_W-1:0]           in_opcode,
   input  logic [NUM_OPS*DATA_W-1:0] in_ops,
   input  logic [IMM_W-1:0]          in_imm,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [OP_W-1:0]           out_opcode,
   output logic [NUM_OPS*DATA_W-1:0] out_ops,
   output logic [IMM_W-1:0]          out_imm
`ifdef IDEX_PERF_CNT_EN
   ,
   output logic [31:0]               stall_cnt,
   output logic [31:0]               flush_drop_cnt
`endif
);

   localparam int OPS_W = NUM_OPS * DATA_W;
   localparam int PL_W  = OP_W + OPS_W + IMM_W;
   localparam logic [PL_W-1:0] NOP_PL = {NOP_OPCODE, {(OPS_W + IMM_W){1'b0}}};

   idex_state_t     r_state;
   idex_state_t     w_next_state;
   logic [PL_W-1:0] r_main;
   logic [PL_W-1:0] r_skid;
   logic            r_in_ready;
   logic [PL_W-1:0] w_in_pl;
   logic            w_out_valid;
   logic            w_accept;
   logic            w_fire;

   assign w_in_pl     = {in_opcode, in_ops, in_imm};
   assign w_out_valid = (r_state != ST_EMPTY);
   assign w_accept    = in_valid & r_in_ready;
   assign w_fire      = w_out_valid & out_ready;

   // State register; in_ready is precomputed from the next state so the
   // decode side sees a flop output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_EMPTY;
         r_in_ready <= 1'b1;
      end else begin
         r_state    <= w_next_state;
         r_in_ready <= (w_next_state != ST_TWO);
      end
   end

   always_comb begin
      w_next_state = r_state;
      if (flush) begin
         w_next_state = ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY: if (w_accept) w_next_state = ST_ONE;
            ST_ONE: begin
               if (w_accept && !w_fire)      w_next_state = ST_TWO;
               else if (!w_accept && w_fire) w_next_state = ST_EMPTY;
            end
            ST_TWO:   if (w_fire) w_next_state = ST_ONE;
            default:  w_next_state = ST_EMPTY;
         endcase
      end
   end

   // Main is kept at the NOP payload whenever the stage is empty, so the
   // outputs come straight from the register with no muxing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_main <= NOP_PL;
         r_skid <= NOP_PL;
      end else if (flush) begin
         r_main <= NOP_PL;
         r_skid <= NOP_PL;
      end else begin
         case (r_state)
            ST_EMPTY: if (w_accept) r_main <= w_in_pl;
            ST_ONE: begin
               if (w_accept && w_fire)  r_main <= w_in_pl;
               else if (w_accept)       r_skid <= w_in_pl;
               else if (w_fire)         r_main <= NOP_PL;
            end
            ST_TWO: begin
               if (w_fire) begin
                  r_main <= r_skid;
                  r_skid <= NOP_PL;
               end
            end
            default: begin
               r_main <= NOP_PL;
               r_skid <= NOP_PL;
            end
         endcase
      end
   end

   always_comb begin
      out_valid                        = w_out_valid;
      {out_opcode, out_ops, out_imm}   = r_main;
      in_ready                         = r_in_ready;
   end

`ifdef IDEX_PERF_CNT_EN
   idex_perf_counters u_perf (
      .clk              (clk),
      .rst_n            (rst_n),
      .i_stall          (w_out_valid & ~out_ready),
      .i_flush          (flush),
      .i_drop_cnt       (idex_entries(r_state)),
      .o_stall_cnt      (stall_cnt),
      .o_flush_drop_cnt (flush_drop_cnt)
   );
`endif

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// tb/tb_id_ex_skid_reg.sv - scoreboard bench for id_ex_skid_reg
module tb_id_ex_skid_reg;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
   logic [4:0]  in_opcode, out_opcode;
   logic [95:0] in_ops, out_ops;
   logic [31:0] in_imm, out_imm;

   logic        s_in_valid, s_in_ready, s_out_valid;
   logic [4:0]  s_in_opcode, s_out_opcode;
   logic [31:0] s_in_ops, s_out_ops;
   logic [7:0]  s_in_imm, s_out_imm;

`ifdef IDEX_PERF_CNT_EN
   logic [31:0] stall_cnt, flush_drop_cnt, s_stall_cnt, s_flush_drop_cnt;
`endif

   id_ex_skid_reg dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_ops(in_ops), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_opcode(out_opcode), .out_ops(out_ops), .out_imm(out_imm)
`ifdef IDEX_PERF_CNT_EN
      , .stall_cnt(stall_cnt), .flush_drop_cnt(flush_drop_cnt)
`endif
   );

   id_ex_skid_reg #(.DATA_W(16), .OP_W(5), .NUM_OPS(2), .IMM_W(8)) dut_s (
      .clk(clk), .rst_n(rst_n), .flush(1'b0),
      .in_valid(s_in_valid), .in_ready(s_in_ready),
      .in_opcode(s_in_opcode), .in_ops(s_in_ops), .in_imm(s_in_imm),
      .out_valid(s_out_valid), .out_ready(1'b1),
      .out_opcode(s_out_opcode), .out_ops(s_out_ops), .out_imm(s_out_imm)
`ifdef IDEX_PERF_CNT_EN
      , .stall_cnt(s_stall_cnt), .flush_drop_cnt(s_flush_drop_cnt)
`endif
   );

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(string nm, logic [159:0] got, logic [159:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
   endtask

   // Reference model: the stage is a FIFO of at most two instructions.
   logic [132:0] exp_q[$];
   bit           m_ready = 1'b1;
   longint       m_stall = 0;
   longint       m_drop  = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         m_ready = 1'b1;
         m_stall = 0;
         m_drop  = 0;
      end else begin
         chk("in_ready", 160'(in_ready), 160'(m_ready));
         chk("out_valid", 160'(out_valid), 160'(exp_q.size() != 0));
         if (exp_q.size() != 0)
            chk("payload", 160'({out_opcode, out_ops, out_imm}), 160'(exp_q[0]));
         else
            chk("bubble", 160'({out_opcode, out_ops, out_imm}), 160'(0));
`ifdef IDEX_PERF_CNT_EN
         chk("stall_cnt", 160'(stall_cnt), 160'(m_stall));
         chk("flush_drop_cnt", 160'(flush_drop_cnt), 160'(m_drop));
`endif
         if (exp_q.size() != 0 && !out_ready) m_stall++;
         if (flush) begin
            m_drop += exp_q.size();
            exp_q.delete();
         end else begin
            if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
            if (in_valid && m_ready) exp_q.push_back({in_opcode, in_ops, in_imm});
         end
         m_ready = (exp_q.size() < 2);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic put(logic [4:0] op, logic [31:0] rd, logic [31:0] rs,
                      logic [31:0] rt, logic [31:0] imm);
      in_valid  = 1'b1;
      in_opcode = op;
      in_ops    = {rt, rs, rd};
      in_imm    = imm;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_opcode = '0; in_ops = '0; in_imm = '0;
      s_in_valid = 1'b0; s_in_opcode = '0; s_in_ops = '0; s_in_imm = '0;
      repeat (3) cyc();
      chk("reset in_ready", 160'(in_ready), 160'(1));
      chk("reset out_valid", 160'(out_valid), 160'(0));
      chk("reset payload", 160'({out_opcode, out_ops, out_imm}), 160'(0));
      rst_n = 1'b1;
      cyc();

      // Narrow instance: payload must pass bit-exact.
      s_in_valid = 1'b1; s_in_opcode = 5'd5; s_in_ops = 32'h1234BEEF; s_in_imm = 8'h5A;
      cyc();
      s_in_valid = 1'b0;
      chk("small valid", 160'(s_out_valid), 160'(1));
      chk("small ops", 160'(s_out_ops), 160'(32'h1234BEEF));
      chk("small imm", 160'(s_out_imm), 160'(8'h5A));
      chk("small op", 160'(s_out_opcode), 160'(5'd5));
      cyc();
      chk("small drained", 160'({s_out_valid, s_out_ops, s_out_imm}), 160'(0));

      // Streaming at full rate.
      put(5'd3, 1, 2, 3, 11);  cyc();
      chk("stream lat", 160'(out_opcode), 160'(3));
      put(5'd11, 6, 9, 8, 14); cyc();
      put(5'd7, 9, 7, 5, 128); cyc();
      in_valid = 1'b0;
      repeat (2) cyc();

      // Back-pressure into TWO, then drain.
      out_ready = 1'b0;
      put(5'd3, 1, 2, 3, 11);  cyc();
      put(5'd11, 6, 9, 8, 14); cyc();
      in_valid = 1'b0;
      chk("bp in_ready", 160'(in_ready), 160'(0));
      chk("bp hold op", 160'(out_opcode), 160'(3));
      cyc();
      out_ready = 1'b1;
      repeat (3) cyc();

      // Flush while TWO with a competing input.
      out_ready = 1'b0;
      put(5'd1, 4, 4, 4, 4); cyc();
      put(5'd2, 5, 5, 5, 5); cyc();
      flush = 1'b1;
      put(5'd7, 1, 1, 1, 1); cyc();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush valid", 160'(out_valid), 160'(0));
      chk("flush op", 160'(out_opcode), 160'(0));
      chk("flush ready", 160'(in_ready), 160'(1));
      out_ready = 1'b1;
      repeat (2) cyc();

      // Back-to-back accept and fire.
      for (int i = 0; i < 10; i++) begin
         put(5'($urandom), $urandom, $urandom, $urandom, $urandom);
         cyc();
      end
      in_valid = 1'b0;
      cyc();

      // Asynchronous reset while stalled in TWO.
      out_ready = 1'b0;
      put(5'd9, 9, 9, 9, 9);  cyc();
      put(5'd10, 1, 2, 3, 4); cyc();
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("areset valid", 160'(out_valid), 160'(0));
      chk("areset ready", 160'(in_ready), 160'(1));
      chk("areset payload", 160'({out_opcode, out_ops, out_imm}), 160'(0));
      cyc();
      rst_n = 1'b1;
      cyc();

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         in_valid  = ($urandom % 4) != 0;
         out_ready = ($urandom % 3) != 0;
         flush     = ($urandom % 40) == 0;
         in_opcode = 5'($urandom);
         in_ops    = {$urandom, $urandom, $urandom};
         in_imm    = $urandom;
         cyc();
      end
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      repeat (4) cyc();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
